// File: rtl/comparator_if.sv
// comparator_if: operand/enable inputs and registered result/flag outputs.
// master drives a_in/b_in/en_in; slave (the comparator) drives y_out/carry/zero.
interface comparator_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             en_in;
  logic [WIDTH-1:0] y_out;
  logic             carry;
  logic             zero;

  modport master (
    output a_in, b_in, en_in,
    input  y_out, carry, zero
  );

  modport slave (
    input  a_in, b_in, en_in,
    output y_out, carry, zero
  );
endinterface

// File: rtl/comparator.sv
// comparator: registered unsigned a-b with borrow (carry) and equal (zero).
// Ports: clk, rst (sync, active-high), bus (slave): a_in, b_in, en_in (low), y_out, carry, zero.
module comparator #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  comparator_if.slave  bus
);

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] y_d, y_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;

  // Extra MSB captures the borrow out of the subtraction.
  assign diff = {1'b0, bus.a_in} - {1'b0, bus.b_in};

  always_comb begin
    y_d     = y_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (!bus.en_in) begin
      y_d     = diff[WIDTH-1:0];
      carry_d = diff[WIDTH];
      zero_d  = (diff[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.y_out = y_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_comparator.sv
// tb_comparator: directed vectors against hand-computed results.
// Each step drives inputs, takes one rising edge, then checks all outputs.
module tb_comparator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  comparator_if #(.WIDTH(8)) bus ();

  comparator #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic       r,
    input logic       en,
    input logic [7:0] a,
    input logic [7:0] b
  );
    rst        = r;
    bus.en_in  = en;
    bus.a_in   = a;
    bus.b_in   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(
    input string      tag,
    input logic [7:0] y,
    input logic       c,
    input logic       z
  );
    chk({tag, ".y"}, bus.y_out, y);
    chk({tag, ".carry"}, {7'd0, bus.carry}, {7'd0, c});
    chk({tag, ".zero"}, {7'd0, bus.zero}, {7'd0, z});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.en_in = 1'b1;
    bus.a_in  = '0;
    bus.b_in  = '0;

    step(1'b1, 1'b0, 8'd0, 8'd0);
    chk3("reset", 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 8'd0);
    chk3("reset_eq_ops", 8'd0, 1'b0, 1'b0);

    step(1'b0, 1'b0, 8'd10, 8'd13);
    chk3("lt", 8'd253, 1'b1, 1'b0);

    step(1'b0, 1'b0, 8'd10, 8'd10);
    chk3("eq", 8'd0, 1'b0, 1'b1);

    step(1'b0, 1'b0, 8'd13, 8'd10);
    chk3("gt1", 8'd3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd13, 8'd10);
    chk3("gt2", 8'd3, 1'b0, 1'b0);

    step(1'b0, 1'b0, 8'd0, 8'd255);
    chk3("min_max", 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'd255, 8'd0);
    chk3("max_min", 8'd255, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    chk3("zero_zero", 8'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd200, 8'd55);
    chk3("gt_big", 8'd145, 1'b0, 1'b0);

    step(1'b0, 1'b0, 8'd10, 8'd13);
    chk3("hold_load", 8'd253, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd10, 8'd10);
    chk3("hold1", 8'd253, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd10, 8'd10);
    chk3("hold2", 8'd253, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd10, 8'd10);
    chk3("hold3", 8'd253, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'd10, 8'd10);
    chk3("hold_release", 8'd0, 1'b0, 1'b1);

    step(1'b0, 1'b0, 8'd13, 8'd10);
    chk3("pre_rst", 8'd3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd13, 8'd10);
    chk3("rst_en0", 8'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd13, 8'd10);
    chk3("rst_en1", 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd13, 8'd10);
    chk3("post_rst_hold", 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd13, 8'd10);
    chk3("post_rst", 8'd3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
